// File: rtl/iq_out_fifo.sv
// iq_out_fifo: I/Q pair output buffer behind the quadratic interpolator.
// Show-ahead FIFO with shared pointers, registered level and almost-full.
module iq_out_fifo #(
  parameter int DATAPATH_WIDTH = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int AFULL_MARGIN   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Write_Enable_i,
  input  logic [DATAPATH_WIDTH-1:0] data_in_I,
  input  logic [DATAPATH_WIDTH-1:0] data_in_Q,
  output logic                      Afull_I_o,
  output logic                      Afull_Q_o,
  input  logic                      rd_en_i,
  output logic [DATAPATH_WIDTH-1:0] I_out,
  output logic [DATAPATH_WIDTH-1:0] Q_out,
  output logic                      valid_o,
  output logic                      full_o,
  output logic                      overflow_o,
  input  logic                      clr_ovf_i,
  output logic [ADDR_WIDTH:0]       level_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam int PW    = 2 * DATAPATH_WIDTH;
  localparam int AF_TH = DEPTH - AFULL_MARGIN;

  localparam logic [LW-1:0] LVL_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL = LW'(AF_TH);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [PW-1:0]         r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_ovf;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_drop;
  logic [LW-1:0]         w_level_nxt;
  logic [PW-1:0]         w_head;
  logic [PW-1:0]         w_wdata;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_DEPTH);

  // A read on an empty FIFO is ignored, so an empty
  // read+write pair degenerates to a plain write.
  assign w_rd_acc = rd_en_i & ~w_empty;

  // When full, a write only fits if a slot is freed
  // by an accepted read on the same edge.
  assign w_wr_acc = Write_Enable_i & (~w_full | w_rd_acc);
  assign w_drop   = Write_Enable_i & w_full & ~w_rd_acc;

  assign w_wdata = {data_in_I, data_in_Q};

  // Next occupancy: +1 on write only, -1 on read only.
  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Sample storage; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  // Write pointer advances on every accepted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
    end else if (w_wr_acc) begin
      r_wr_ptr <= r_wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances on every accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
    end else if (w_rd_acc) begin
      r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Registered occupancy counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= '0;
    end else begin
      r_level <= w_level_nxt;
    end
  end

  // Sticky overflow; a drop on the clearing edge wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf_i) begin
      r_ovf <= 1'b0;
    end
  end

  // Head word; zeros whenever nothing is stored so the
  // outputs clear as soon as reset empties the FIFO.
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign I_out      = w_head[PW-1:DATAPATH_WIDTH];
  assign Q_out      = w_head[DATAPATH_WIDTH-1:0];
  assign valid_o    = ~w_empty;
  assign full_o     = w_full;
  assign overflow_o = r_ovf;
  assign level_o    = r_level;
  assign Afull_I_o  = (r_level >= LVL_AFULL);
  assign Afull_Q_o  = (r_level >= LVL_AFULL);

endmodule

// File: doc/iq_out_fifo.md
# iq_out_fifo

Output buffer for the quadratic interpolator stage (intpol2_D4). Captures each interpolated I/Q sample pair written under the interpolator's write-enable strobe and holds it in a shared-pointer FIFO. Returns the almost-full backpressure the interpolator samples on its Afull_I_in/Afull_Q_in inputs. Presents samples to the downstream consumer (DAC/modulator) through a show-ahead read port.

## Interface
Parameters:
- DATAPATH_WIDTH, 32, width of each I and Q sample
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2^ADDR_WIDTH (16)
- AFULL_MARGIN, 4, free slots remaining when Afull asserts; legal range 1..DEPTH-1

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- Write_Enable_i  in  1  write strobe from interpolator Write_Enable_o
- data_in_I  in  DATAPATH_WIDTH  I sample, from interpolator I_interp
- data_in_Q  in  DATAPATH_WIDTH  Q sample, from interpolator Q_interp
- Afull_I_o  out  1  almost-full, to interpolator Afull_I_in
- Afull_Q_o  out  1  almost-full, to interpolator Afull_Q_in; always equal to Afull_I_o
- rd_en_i  in  1  consumer pop request
- I_out  out  DATAPATH_WIDTH  head-of-FIFO I sample
- Q_out  out  DATAPATH_WIDTH  head-of-FIFO Q sample
- valid_o  out  1  head sample valid (FIFO not empty)
- full_o  out  1  level == DEPTH
- overflow_o  out  1  sticky: a write was dropped
- clr_ovf_i  in  1  clears overflow_o
- level_o  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH

## Operation
- Storage: one DEPTH x (2*DATAPATH_WIDTH) array. I and Q are written and read as a pair. Pointers: wr_ptr and rd_ptr, ADDR_WIDTH bits, wrap modulo DEPTH. Occupancy is held in a registered counter, level.
- Write accepted when Write_Enable_i=1 and either level<DEPTH, or level==DEPTH and a read is accepted in the same cycle. On accept: mem[wr_ptr] <= {data_in_I, data_in_Q}; wr_ptr++.
- Write dropped when Write_Enable_i=1, level==DEPTH and no read is accepted. On drop: memory and pointers are unchanged and overflow_o is set.
- Read accepted when rd_en_i=1 and level>0; rd_ptr++. rd_en_i while empty is ignored and has no error flag.
- Simultaneous accepted read and write: level unchanged.
- Empty plus simultaneous read and write: the write is accepted and the read is ignored. There is no write-through to the output.
- level next value = level + wr_acc - rd_acc.
- Show-ahead outputs: I_out/Q_out = mem[rd_ptr] when level>0, else all zeros. valid_o = (level>0).
- Afull_I_o = Afull_Q_o = (level >= DEPTH - AFULL_MARGIN). The flag is combinational from the registered level.
- full_o = (level == DEPTH).
- overflow_o: set by a dropped write and cleared by clr_ovf_i. When a set and a clear occur in the same cycle, set wins.
- Data values are passed through unmodified. There is no arithmetic on samples.

## Timing
- Reset (rst=0, async): wr_ptr=0, rd_ptr=0, level=0, overflow=0. Outputs during and after reset: valid_o=0, I_out=Q_out=0, Afull=0, full_o=0, overflow_o=0, level_o=0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored samples immediately. The first write after rst deasserts lands at address 0.
- Write-to-read latency: a sample written at edge N appears on I_out/Q_out with valid_o=1 after edge N (visible in cycle N+1) if the FIFO was empty.
- Pop: after the edge where rd_en_i=1 and valid_o=1, the next sample or zeros is presented.
- Afull, full_o and level_o update one edge after the write or read that changes level.
- The interpolator may issue up to AFULL_MARGIN further writes after observing Afull without any loss.
- Pointer wrap: DEPTH-1 -> 0 with no bubble.

## Test plan
- Reset/idle: hold rst=0 with random inputs. Required: all outputs 0. Release rst with no strobes: outputs remain 0 and level_o=0.
- Ordered pass-through: write pairs (I=k, Q=-k) for k=1..20, popping continuously after k=1. Required: outputs read out 1..20 in order with matching Q; level_o never exceeds 2; each pointer wraps past 15 without error.
- Almost-full threshold (DEPTH=16, MARGIN=4), no reads: write 11 pairs -> Afull=0. 12th write -> Afull_I_o=Afull_Q_o=1 on the following cycle. Pop 1 -> Afull=0 on the cycle after the pop.
- Overflow: write 16 pairs, then write pair 17 with rd_en_i=0. Required: full_o=1, overflow_o=1, level_o=16. Draining 16 pops returns pairs 1..16 (pair 17 is lost).
- Full with simultaneous read and write: at level 16, assert Write_Enable_i and rd_en_i together. Required: level stays 16, overflow_o stays 0, pair 1 is popped and the new pair is stored at tail. Clear overflow with clr_ovf_i while a drop occurs in the same cycle -> overflow_o remains 1.
- Empty with simultaneous read and write, plus async reset: at level 0, assert both -> level_o=1 and valid_o=1 with the new pair on the outputs. Then assert rst mid-burst at level 7 -> all outputs 0 immediately, before any clock edge.
